// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default timing, used by both tx and rx sides.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // 100 MHz core clock at 115200 baud
  localparam int CLKS_PER_BIT_DEF = 868;
  localparam int DATA_W_DEF       = 8;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps; held at 0 while clear is high.
// bit_end marks the last cycle of a period, bit_pre the cycle before it (lets callers register period-end outputs).
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end,
  output logic bit_pre
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] baud_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
    end else if (clear || bit_end) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + CW'(1);
    end
  end

  assign bit_end = (baud_cnt == LAST);
  assign bit_pre = (baud_cnt == PRE);

endmodule

// File: rtl/uart_tx_ctrl.sv
// 8N1 UART transmit controller driving an external load/shift-right serialiser; accept-to-idle is 10 bit periods.
// tx_start is ignored while busy (no queuing). Define UART_TX_PARITY_EN to add an even-parity bit (11 periods).
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_W       = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              sr_load,
  output logic              sr_enable,
  output logic [DATA_W-1:0] sr_data,
  input  logic              sr_lsb,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  uart_state_t       state, state_nxt;
  logic [BW-1:0]     bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0] sr_data_nxt;
  logic              busy_nxt, sr_load_nxt, sr_enable_nxt, done_nxt;
  logic              bit_end, bit_pre, clear;

  // Counter parks at zero in IDLE so every frame starts on a fresh period.
  assign clear = (state == ST_IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .bit_end (bit_end),
    .bit_pre (bit_pre)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      sr_data   <= '0;
      busy      <= 1'b0;
      sr_load   <= 1'b0;
      sr_enable <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      sr_data   <= sr_data_nxt;
      busy      <= busy_nxt;
      sr_load   <= sr_load_nxt;
      sr_enable <= sr_enable_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    sr_data_nxt   = sr_data;
    busy_nxt      = busy;
    sr_load_nxt   = 1'b0;
    sr_enable_nxt = 1'b0;
    done_nxt      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tx_start) begin
          sr_data_nxt = tx_data;
          state_nxt   = ST_START;
          busy_nxt    = 1'b1;
          sr_load_nxt = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_nxt   = ST_DATA;
          bit_cnt_nxt = '0;
        end
      end
      ST_DATA: begin
        // Registered pulse lands in the last cycle of the bit, so the shift hits the boundary edge.
        sr_enable_nxt = bit_pre;
        if (bit_end) begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
            state_nxt   = ST_PARITY;
`else
            state_nxt   = ST_STOP;
`endif
          end else begin
            bit_cnt_nxt = bit_cnt + BW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_nxt = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        done_nxt = bit_pre;
        if (bit_end) begin
          state_nxt = ST_IDLE;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      ST_START: tx = 1'b0;
      ST_DATA:  tx = sr_lsb;
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx = ^sr_data;
`endif
      default:  tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl with a behavioural load/shift-right serialiser; line bits compared mid-bit against a frame model.
// Honours UART_TX_PARITY_EN for frame length and the parity bit.
module tb_uart_tx_ctrl;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * C;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       sr_load;
  logic       sr_enable;
  logic [7:0] sr_data;
  logic       sr_lsb;
  logic       tx;
  logic       busy;
  logic       done;
  logic [7:0] ser_q = 8'h00;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(
    .CLKS_PER_BIT(C),
    .DATA_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .sr_load   (sr_load),
    .sr_enable (sr_enable),
    .sr_data   (sr_data),
    .sr_lsb    (sr_lsb),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  // Downstream serialiser: load wins, otherwise shift right on enable.
  always @(posedge clk) begin
    if (sr_load)        ser_q <= sr_data;
    else if (sr_enable) ser_q <= {1'b0, ser_q[7:1]};
  end
  assign sr_lsb = ser_q[0];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Line level of bit k of an 8N1 (or 8E1) frame carrying b.
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the first cycle after the frame.
  task automatic run_frame(input logic [7:0] b, input bit hold, input logic [7:0] alt, input string name);
    int loads = 0, load_cyc = 0, enables = 0, en_stray = 0, overlap = 0;
    int dones = 0, done_cyc = 0, busy_low = 0, k;
    tx_start = 1'b1;
    tx_data  = b;
    @(posedge clk);
    for (int cyc = 1; cyc <= FRAME; cyc++) begin
      @(negedge clk);
      k = (cyc - 1) / C;
      if (sr_load) begin loads++; load_cyc = cyc; end
      if (sr_enable) begin
        enables++;
        if (k < 1 || k > 8) en_stray++;
      end
      if (sr_load && sr_enable) overlap++;
      if (done) begin dones++; done_cyc = cyc; end
      if (!busy) busy_low++;
      if ((cyc - 1) % C == C / 2)
        chk($sformatf("%s_bit%0d", name, k), {31'd0, tx}, {31'd0, exp_bit(b, k)});
      if (cyc == 2) chk({name, "_sr_data"}, {24'd0, sr_data}, {24'd0, b});
      if (cyc == 1 && !hold) begin
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
      end
      if (cyc == 15 && hold) tx_data = alt;
    end
    chk({name, "_loads"},    loads,    1);
    chk({name, "_load_cyc"}, load_cyc, 1);
    chk({name, "_enables"},  enables,  8);
    chk({name, "_en_stray"}, en_stray, 0);
    chk({name, "_overlap"},  overlap,  0);
    chk({name, "_dones"},    dones,    1);
    chk({name, "_done_cyc"}, done_cyc, FRAME);
    chk({name, "_busy_low"}, busy_low, 0);
    @(negedge clk);
    chk({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_idle_tx"},   {31'd0, tx},   32'd1);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_tx"},     {31'd0, tx},        32'd1);
    chk({name, "_busy"},   {31'd0, busy},      32'd0);
    chk({name, "_done"},   {31'd0, done},      32'd0);
    chk({name, "_load"},   {31'd0, sr_load},   32'd0);
    chk({name, "_enable"}, {31'd0, sr_enable}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int stray;
    rst      = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk_idle("rst");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("post_rst");

    run_frame(8'hA5, 1'b0, 8'h00, "a5");

    // Start held through the frame: data change mid-frame must not leak in.
    run_frame(8'h5A, 1'b1, 8'h3C, "hold");
    run_frame(8'h3C, 1'b0, 8'h00, "hold2");

    // Reset during data bit 3 abandons the frame at once.
    tx_start = 1'b1;
    tx_data  = 8'($urandom);
    @(posedge clk);
    for (int cyc = 1; cyc <= 4 * C + 2; cyc++) begin
      @(negedge clk);
      if (cyc == 1) tx_start = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk_idle("midrst");
    @(negedge clk);
    rst   = 1'b0;
    stray = 0;
    for (int cyc = 0; cyc < FRAME + 4; cyc++) begin
      @(negedge clk);
      if (done || busy || !tx) stray++;
    end
    chk("midrst_quiet", stray, 0);
    run_frame(8'h0F, 1'b0, 8'h00, "f0");

    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_frame(8'($urandom), 1'b0, 8'h00, $sformatf("rnd%0d", i));
    end

`ifdef UART_TX_PARITY_EN
    run_frame(8'h07, 1'b0, 8'h00, "par07");
    run_frame(8'h03, 1'b0, 8'h00, "par03");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
